// File: rtl/fifo_flex_pkg.sv
// Shared types for the flexible FIFO: per-cycle occupancy operation encoding.
package fifo_flex_pkg;

    // Encoded as {push, pop} so the two strobes can be cast directly.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : fifo_flex_pkg

// File: rtl/fifo_flex.sv
// Synchronous FIFO with arbitrary depth, threshold flags and optional empty bypass.
// Latency: 1 cycle write-to-read; 0 cycles when Bypass=1 and the FIFO is empty.
// Backpressure: wr_ready_o drops at full (no write while full, even with a read); rd_valid_o drops when empty.
module fifo_flex
    import fifo_flex_pkg::*;
#(
    parameter int unsigned Width             = 32,
    parameter int unsigned Depth             = 4,
    parameter int unsigned AlmostFullThresh  = Depth - 1,
    parameter int unsigned AlmostEmptyThresh = 1,
    parameter bit          Bypass            = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       wr_valid_i,
    input  logic [Width-1:0]           wr_data_i,
    output logic                       wr_ready_o,
    input  logic                       rd_ready_i,
    output logic [Width-1:0]           rd_data_o,
    output logic                       rd_valid_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       almost_full_o,
    output logic                       almost_empty_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    if (Depth < 2) begin : g_bad_depth
        $error("fifo_flex: Depth must be at least 2");
    end
    if (AlmostFullThresh > Depth) begin : g_bad_af
        $error("fifo_flex: AlmostFullThresh exceeds Depth");
    end
    if (AlmostEmptyThresh > Depth) begin : g_bad_ae
        $error("fifo_flex: AlmostEmptyThresh exceeds Depth");
    end

    // Explicit wrap keeps non-power-of-two depths from ever addressing index Depth.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  count_q;
    logic             empty;
    logic             bypass_hit;
    logic             wr_fire;
    logic             rd_fire;
    logic             push;
    logic             pop;
    fifo_op_e         op;

    assign empty      = (count_q == '0);
    assign bypass_hit = Bypass & empty;

    assign wr_ready_o = (count_q < CntW'(Depth));
    assign rd_valid_o = ~empty | (bypass_hit & wr_valid_i);
    assign rd_data_o  = bypass_hit ? wr_data_i : mem[rd_ptr];

    assign wr_fire = wr_valid_i & wr_ready_o;
    assign rd_fire = rd_valid_o & rd_ready_i;

    // A bypassed transfer consumes the write directly, so neither side touches storage.
    assign push = wr_fire & ~(bypass_hit & rd_fire);
    assign pop  = rd_fire & ~bypass_hit;
    assign op   = fifo_op_e'({push, pop});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case (op)
                OP_PUSH: count_q <= count_q + CntW'(1);
                OP_POP:  count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= wr_data_i;
        end
    end

    assign count_o        = count_q;
    assign almost_full_o  = (count_q >= CntW'(AlmostFullThresh));
    assign almost_empty_o = (count_q <= CntW'(AlmostEmptyThresh));

endmodule : fifo_flex

// File: tb/tb_fifo_flex.sv
// Directed self-checking bench: a Depth=5 FIFO without bypass and one with bypass.
module tb_fifo_flex;

    logic       clk_i = 1'b0;
    logic       rst_ni;

    logic       flush_i, wr_valid_i, rd_ready_i;
    logic [7:0] wr_data_i;
    logic       wr_ready_o, rd_valid_o, almost_full_o, almost_empty_o;
    logic [7:0] rd_data_o;
    logic [2:0] count_o;

    logic       b_flush, b_wr_valid, b_rd_ready;
    logic [7:0] b_wr_data;
    logic       b_wr_ready, b_rd_valid, b_af, b_ae;
    logic [7:0] b_rd_data;
    logic [2:0] b_count;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk_i = ~clk_i;

    fifo_flex #(.Width(8), .Depth(5), .AlmostFullThresh(4), .AlmostEmptyThresh(1), .Bypass(1'b0)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
        .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
        .count_o(count_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o)
    );

    fifo_flex #(.Width(8), .Depth(5), .AlmostFullThresh(4), .AlmostEmptyThresh(1), .Bypass(1'b1)) u_byp (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(b_flush),
        .wr_valid_i(b_wr_valid), .wr_data_i(b_wr_data), .wr_ready_o(b_wr_ready),
        .rd_ready_i(b_rd_ready), .rd_data_o(b_rd_data), .rd_valid_o(b_rd_valid),
        .count_o(b_count), .almost_full_o(b_af), .almost_empty_o(b_ae)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni     = 1'b0;
        flush_i    = 1'b0; wr_valid_i = 1'b0; rd_ready_i = 1'b0; wr_data_i = 8'h00;
        b_flush    = 1'b0; b_wr_valid = 1'b0; b_rd_ready = 1'b0; b_wr_data = 8'h00;
        #2;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("rst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("rst_almost_empty", 32'(almost_empty_o), 32'd1);
        chk("rst_almost_full", 32'(almost_full_o), 32'd0);
        #10;
        rst_ni = 1'b1;
        step();

        // Fill to full, checking occupancy and flags after each write.
        for (int i = 1; i <= 5; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'(i);
            step();
            chk("fill_count", 32'(count_o), 32'(i));
            chk("fill_af", 32'(almost_full_o), (i >= 4) ? 32'd1 : 32'd0);
            chk("fill_ae", 32'(almost_empty_o), (i <= 1) ? 32'd1 : 32'd0);
        end
        wr_valid_i = 1'b0;
        chk("full_wr_ready", 32'(wr_ready_o), 32'd0);
        chk("full_head", 32'(rd_data_o), 32'h01);

        // Full with simultaneous read and write: read succeeds, write is refused.
        wr_valid_i = 1'b1; wr_data_i = 8'h99; rd_ready_i = 1'b1;
        #1;
        chk("fullrw_rd_data", 32'(rd_data_o), 32'h01);
        step();
        wr_valid_i = 1'b0;
        chk("fullrw_count", 32'(count_o), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            #1;
            chk("drain_data", 32'(rd_data_o), 32'(i));
            chk("drain_valid", 32'(rd_valid_o), 32'd1);
            step();
        end
        rd_ready_i = 1'b0;
        chk("drain_count", 32'(count_o), 32'd0);
        chk("drain_rd_valid", 32'(rd_valid_o), 32'd0);

        // Fill three, then stream with simultaneous read/write so pointers wrap repeatedly.
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h10 + 8'(i);
            step();
        end
        rd_ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            wr_data_i = 8'h13 + 8'(k);
            #1;
            chk("stream_data", 32'(rd_data_o), 32'h10 + 32'(k));
            step();
            chk("stream_count", 32'(count_o), 32'd3);
        end
        wr_valid_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stream_tail", 32'(rd_data_o), 32'h24 + 32'(k));
            step();
        end
        rd_ready_i = 1'b0;
        chk("stream_empty", 32'(count_o), 32'd0);

        // Flush at count 3 with a concurrent write that must be lost.
        for (int i = 0; i < 3; i++) begin
            wr_valid_i = 1'b1;
            wr_data_i  = 8'h31 + 8'(i);
            step();
        end
        wr_data_i = 8'h77; flush_i = 1'b1;
        #1;
        chk("flush_wr_ready", 32'(wr_ready_o), 32'd1);
        chk("flush_rd_valid", 32'(rd_valid_o), 32'd1);
        step();
        flush_i = 1'b0; wr_valid_i = 1'b0;
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_rd_valid_after", 32'(rd_valid_o), 32'd0);
        wr_valid_i = 1'b1; wr_data_i = 8'h55;
        step();
        wr_data_i = 8'h56;
        chk("post_flush_data", 32'(rd_data_o), 32'h55);
        chk("post_flush_count", 32'(count_o), 32'd1);
        step();
        wr_valid_i = 1'b0;
        chk("pre_rst_count", 32'(count_o), 32'd2);

        // Bypass instance: empty write with reader ready passes straight through.
        b_wr_valid = 1'b1; b_wr_data = 8'hAA; b_rd_ready = 1'b1;
        #1;
        chk("byp_valid", 32'(b_rd_valid), 32'd1);
        chk("byp_data", 32'(b_rd_data), 32'hAA);
        step();
        chk("byp_count", 32'(b_count), 32'd0);
        b_rd_ready = 1'b0; b_wr_data = 8'hBB;
        #1;
        chk("byp_noready_valid", 32'(b_rd_valid), 32'd1);
        step();
        b_wr_valid = 1'b0;
        chk("byp_stored_count", 32'(b_count), 32'd1);
        chk("byp_stored_data", 32'(b_rd_data), 32'hBB);
        b_wr_valid = 1'b1; b_wr_data = 8'hCC; b_rd_ready = 1'b1;
        step();
        b_wr_valid = 1'b0;
        chk("byp_rw_count", 32'(b_count), 32'd1);
        chk("byp_rw_data", 32'(b_rd_data), 32'hCC);
        step();
        b_rd_ready = 1'b0;
        chk("byp_drained", 32'(b_count), 32'd0);

        // Asynchronous reset pulse between edges at count 2.
        #3;
        rst_ni = 1'b0;
        #1;
        chk("arst_count", 32'(count_o), 32'd0);
        chk("arst_rd_valid", 32'(rd_valid_o), 32'd0);
        chk("arst_wr_ready", 32'(wr_ready_o), 32'd1);
        #2;
        rst_ni = 1'b1;
        step();
        chk("arst_count_after", 32'(count_o), 32'd0);
        chk("arst_rd_valid_after", 32'(rd_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_fifo_flex
